// File: rtl/sat_accumulator.sv
// Saturating frame accumulator: sums signed operands per frame, clamping at every step,
// and hands the frame total, sticky overflow flag and sample count downstream.
module sat_accumulator #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       out_count
);

  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [7:0]       count;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum_sat;
  logic             sat_hit;
  logic [7:0]       count_next;
  logic             frame_end;

  // Handshakes: a transfer happens on any rising edge where valid and ready are both 1.
  // Input and output never transfer in the same cycle, so each frame costs one bubble.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  always_comb begin
    sum_ext = {acc[WIDTH-1], acc} + {in_data[WIDTH-1], in_data};
    sum_sat = sum_ext[WIDTH-1:0];
    sat_hit = 1'b0;
    // The top two bits of the extended sum disagree only when the true sum left the range.
    if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
      sat_hit = 1'b1;
      sum_sat = sum_ext[WIDTH] ? SAT_MIN : SAT_MAX;
    end
    count_next = count + 8'd1;
    frame_end  = in_last || (count_next == 8'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      ovf       <= 1'b0;
      count     <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (state == ACC) begin
      if (in_valid) begin
        if (frame_end) begin
          out_sum   <= sum_sat;
          out_ovf   <= ovf | sat_hit;
          out_count <= count_next;
          acc       <= '0;
          ovf       <= 1'b0;
          count     <= '0;
          state     <= HOLD;
        end else begin
          acc   <= sum_sat;
          ovf   <= ovf | sat_hit;
          count <= count_next;
        end
      end
    end else begin
      if (out_ready) begin
        state <= ACC;
      end
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: hand-computed frame results, backpressure and reset cases.
module tb_sat_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_count;

  int pass_cnt;
  int total_cnt;

  sat_accumulator #(.WIDTH(16), .MAX_LEN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    check("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'hdead;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] s, input logic o,
                               input logic [7:0] c);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_sum"}, out_sum, s);
    check({tag, "_ovf"}, out_ovf, o);
    check({tag, "_count"}, out_count, c);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_after_take"}, out_valid, 0);
    check({tag, "_ready_after_take"}, in_ready, 1);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    tick();

    // 1: 50 + 150 with out_ready held high throughout
    out_ready = 1'b1;
    send(16'd50, 1'b0);
    check("t1_no_valid_mid_frame", out_valid, 0);
    send(16'd150, 1'b1);
    expect_result("t1", 16'd200, 1'b0, 8'd2);
    tick();
    check("t1_valid_one_cycle", out_valid, 0);
    check("t1_back_to_acc", in_ready, 1);
    out_ready = 1'b0;

    // 2: 1250 - 1300 with idle cycles between operands
    send(16'd1250, 1'b0);
    repeat (2) tick();
    check("t2_idle_no_valid", out_valid, 0);
    send(16'(-1300), 1'b1);
    expect_result("t2", 16'(-50), 1'b0, 8'd2);
    take_result("t2");

    // 3: positive clamp then recovery, sticky ovf
    send(16'd30000, 1'b0);
    send(16'd30000, 1'b0);
    send(16'(-10000), 1'b1);
    expect_result("t3_pos", 16'd22767, 1'b1, 8'd3);
    take_result("t3_pos");

    send(16'(-30000), 1'b0);
    send(16'(-30000), 1'b1);
    expect_result("t3_neg", 16'h8000, 1'b1, 8'd2);
    take_result("t3_neg");

    // 4: MAX_LEN forces frame end; ovf cleared from previous frame
    for (int i = 0; i < 7; i++) send(16'd1, 1'b0);
    check("t4_no_valid_at_7", out_valid, 0);
    send(16'd1, 1'b0);
    expect_result("t4_max", 16'd8, 1'b0, 8'd8);
    take_result("t4_max");
    send(16'd5, 1'b1);
    expect_result("t4_next", 16'd5, 1'b0, 8'd1);
    take_result("t4_next");

    // in_last on exactly the MAX_LEN-th sample: one frame only
    for (int i = 0; i < 7; i++) send(16'd2, 1'b0);
    send(16'd2, 1'b1);
    expect_result("t4_last_at_max", 16'd16, 1'b0, 8'd8);
    take_result("t4_last_at_max");
    tick();
    check("t4_no_extra_frame", out_valid, 0);

    // 5: backpressure, in_valid pulses ignored in HOLD
    send(16'd3, 1'b0);
    send(16'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      expect_result("t5_hold", 16'd7, 1'b0, 8'd2);
      in_valid = 1'b1;
      in_data  = 16'd1000;
      in_last  = (i == 2);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    expect_result("t5_hold_end", 16'd7, 1'b0, 8'd2);
    take_result("t5");
    send(16'd10, 1'b1);
    expect_result("t5_after", 16'd10, 1'b0, 8'd1);
    take_result("t5_after");

    // 6: reset mid-frame discards partial sum
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_mid_valid", out_valid, 0);
    check("t6_rst_mid_ready", in_ready, 1);
    send(16'd7, 1'b1);
    expect_result("t6_resume", 16'd7, 1'b0, 8'd1);

    // reset while holding a result
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_hold_valid", out_valid, 0);
    check("t6_rst_hold_sum", out_sum, 0);
    check("t6_rst_hold_ovf", out_ovf, 0);
    check("t6_rst_hold_count", out_count, 0);
    check("t6_rst_hold_ready", in_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
